mem_ctrl: RTL
=============

// Module: mem_ctrl
// PURPOSE
//  Clocked, parametrised memory unit; next generation of the async MAR/MBR RAM front end.
//  Holds MAR/MBR and an internal byte RAM of PARTS partitions, with zero-page masking.
//  Adds a req/ready handshake, programmable wait states, byte or little-endian word
//  transfers and optional MAR auto-increment. Sits between CPU control unit and data bus.
// PARAMETERS
//  DW          8   data byte width (bits)
//  AW          16  address width per partition; RAM depth = PARTS * 2**AW bytes
//  PARTS       2   number of memory partitions (>=1)
//  PW          1   partition select width, $clog2(PARTS), min 1
//  WAIT_STATES 0   extra cycles per byte access (0..15)
//  AUTO_INC    1   1 = MAR += bytes transferred on completion; 0 = MAR unchanged
// PORTS
//  clk        in   1     clock, all state updates on rising edge
//  rst        in   1     synchronous reset, active-high
//  req        in   1     access request, sampled only when ready=1
//  we         in   1     1 = write, 0 = read (sampled with req)
//  word       in   1     1 = 2-byte access, 0 = 1-byte (sampled with req)
//  zero_page  in   1     active low: 0 forces MAR[AW-1:8] to 0 for the access
//  part       in   PW    partition select (sampled with req); values >= PARTS map to PARTS-1
//  mar_load   in   1     load MAR from address
//  address    in   AW    MAR load value
//  mbr_load   in   1     load MBR from wdata (ignored while ready=0)
//  wdata      in   2*DW  MBR load value; low byte at the lower address
//  mar        out  AW    current MAR
//  mbr        out  2*DW  current MBR; read data lands here
//  ready      out  1     1 = idle, request may be issued
//  done       out  1     one-cycle pulse when an access completes
// BEHAVIOUR
//  Reset: state=IDLE, mar=0, mbr=0, ready=1, done=0, wait counter=0. RAM not cleared;
//   contents undefined until written.
//  Effective address EA = {part, mar[AW-1:8] & {AW-8{zero_page}}, mar[7:0]}. Latched at accept.
//  FSM: IDLE -> ACC0 -> (word ? ACC1 : DONE) -> DONE -> IDLE.
//   IDLE: ready=1. req=1 accepts at cycle T: latch we, word, EA, MBR snapshot; next ACC0.
//   ACC0: hold WAIT_STATES+1 cycles (counter); on last cycle edge write mbr[DW-1:0] to EA,
//    or capture RAM[EA] into mbr[DW-1:0]. Read byte: mbr[2*DW-1:DW] cleared to 0.
//   ACC1: same timing, byte 1 at EA2 = EA+1 with mbr[2*DW-1:DW].
//   DONE: done=1, ready=0 for exactly one cycle; MAR update applied; next IDLE.
//  Latency: byte done at T+WAIT_STATES+2; word done at T+2*WAIT_STATES+3.
//  ready deasserts the cycle after accept; reasserts the cycle after DONE.
//  Wrap: EA2 increments low AW bits mod 2**AW inside the latched partition, never crossing it.
//   With zero_page=0 the upper bits stay 0, so 0x00FF -> 0x0000 (page-0 wrap).
//  Auto-inc (AUTO_INC=1): in DONE, mar <= mar + (word ? 2 : 1), mod 2**AW, zero_page ignored.
//  MAR load: mar_load accepted in any state. Same cycle as auto-inc: mar_load wins.
//   Loads during an access do not affect the latched EA.
//  MBR: mbr_load honoured only when ready=1. Same cycle as req: MBR takes wdata;
//   the write uses that new value.
//  req while ready=0 is ignored, not queued. req held high re-issues every access.
//  rst mid-access: immediate return to IDLE. A byte whose commit edge has not occurred
//   is not written; an already-written byte stays. done is not pulsed.
// TESTING
//  1 Reset: rst 2 cycles -> ready=1, done=0, mar=0, mbr=0.
//  2 Byte write/read W=0, part=0, zero_page=1: MAR=0x1234, MBR=0x00A5, we=1.
//    Expect done at T+2. Read back -> mbr=0x00A5, mar=0x1236 after both accesses.
//  3 Word with wrap, zero_page=0: MAR=0xAAFF, write 0xBEEF.
//    Expect RAM[p0:0x00FF]=0xEF, RAM[p0:0x0000]=0xBE, done at T+3.
//  4 Partitions: write 0x11 at part=0, 0x22 at part=1, both addr 0x0040.
//    Readback each -> 0x11 / 0x22, no aliasing.
//  5 WAIT_STATES=3: word read -> done exactly T+9. Mid-access req, mbr_load ignored.
//    mar_load+auto-inc in DONE -> mar=address.
//  6 Reset during a word write between the byte-0 and byte-1 commit edges.
//    Expect byte 0 written, byte 1 unchanged, no done, ready=1 next cycle.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: clocked MAR/MBR front end over a partitioned byte RAM.
// Handshaked byte/word accesses with wait states and MAR auto-increment.
module mem_ctrl #(
  parameter int DW          = 8,
  parameter int AW          = 16,
  parameter int PARTS       = 2,
  parameter int PW          = 1,
  parameter int WAIT_STATES = 0,
  parameter int AUTO_INC    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic          word,
  input  logic          zero_page,
  input  logic [PW-1:0] part,
  input  logic          mar_load,
  input  logic [AW-1:0] address,
  input  logic          mbr_load,
  input  logic [2*DW-1:0] wdata,
  output logic [AW-1:0] mar,
  output logic [2*DW-1:0] mbr,
  output logic          ready,
  output logic          done
);

  localparam int DEPTH = PARTS * (2 ** AW);

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [3:0]    cnt;
  logic          lat_we;
  logic          lat_word;
  logic          lat_zp;
  logic [PW-1:0] lat_part;
  logic [PW-1:0] part_eff;
  logic [AW-1:0] lat_addr;
  logic [AW-1:0] addr2;
  logic [AW-1:0] acc_addr;
  logic [PW+AW-1:0] idx;
  logic          in_acc;
  logic          last;
  logic          commit;
  logic [DW-1:0] rd_byte;
  logic [DW-1:0] wr_byte;

  logic [DW-1:0] ram [DEPTH];

  assign part_eff = (int'(part) >= PARTS) ? PW'(PARTS - 1) : part;

  // Page-0 accesses wrap inside the page instead of carrying upward
  assign addr2 = lat_zp ? lat_addr + AW'(1)
                        : {{(AW-8){1'b0}}, lat_addr[7:0] + 8'd1};

  assign acc_addr = (state == ACC1) ? addr2 : lat_addr;
  assign idx      = {lat_part, acc_addr};
  assign in_acc   = (state == ACC0) || (state == ACC1);
  assign last     = (cnt == 4'(WAIT_STATES));
  assign commit   = in_acc && last;
  assign rd_byte  = ram[idx];
  assign wr_byte  = (state == ACC1) ? mbr[2*DW-1:DW] : mbr[DW-1:0];

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (req) state_nx = ACC0;
      end
      ACC0: begin
        if (last) state_nx = lat_word ? ACC1 : DONE;
      end
      ACC1: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      mar   <= '0;
      mbr   <= '0;
    end else begin
      state <= state_nx;
      if (in_acc && !last) cnt <= cnt + 4'd1;
      else cnt <= '0;
      if (mar_load) mar <= address;
      else if (state == DONE && AUTO_INC != 0)
        mar <= mar + (lat_word ? AW'(2) : AW'(1));
      if (ready && mbr_load) begin
        mbr <= wdata;
      end else if (commit && !lat_we) begin
        if (state == ACC1) begin
          mbr[2*DW-1:DW] <= rd_byte;
        end else begin
          mbr[DW-1:0] <= rd_byte;
          if (!lat_word) mbr[2*DW-1:DW] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      lat_we   <= we;
      lat_word <= word;
      lat_zp   <= zero_page;
      lat_part <= part_eff;
      lat_addr <= {mar[AW-1:8] & {(AW-8){zero_page}}, mar[7:0]};
    end
  end

  // A reset on the commit edge cancels that byte
  always_ff @(posedge clk) begin
    if (!rst && commit && lat_we) ram[idx] <= wr_byte;
  end

endmodule
